// File: rtl/seq_divider32.sv
// Multi-cycle signed divider: radix-2 restoring division on operand magnitudes,
// followed by a single sign-fixup cycle. Start/done handshake toward the ALU FSM.
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             signQuot_q, signQuot_d;
  logic             signRem_q, signRem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remOut_q, remOut_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trialRem;
  logic [WIDTH:0]   trialDiff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      signQuot_q <= 1'b0;
      signRem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      remOut_q   <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      signQuot_q <= signQuot_d;
      signRem_q  <= signRem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      remOut_q   <= remOut_d;
      dbz_q      <= dbz_d;
    end
  end

  // The dividend register doubles as the quotient: its MSB feeds the partial
  // remainder while the new quotient bit enters at the LSB.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    signQuot_d = signQuot_q;
    signRem_d  = signRem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quot_d     = quot_q;
    remOut_d   = remOut_q;
    dbz_d      = dbz_q;
    trialRem   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    trialDiff  = trialRem - {1'b0, dvsr_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op2 == '0) begin
            quot_d   = '1;
            remOut_d = op1;
            dbz_d    = 1'b1;
            done_d   = 1'b1;
          end else begin
            signQuot_d = op1[WIDTH-1] ^ op2[WIDTH-1];
            signRem_d  = op1[WIDTH-1];
            dvd_d      = op1[WIDTH-1] ? -op1 : op1;
            dvsr_d     = op2[WIDTH-1] ? -op2 : op2;
            rem_d      = '0;
            cnt_d      = CW'(WIDTH - 1);
            busy_d     = 1'b1;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        if (!trialDiff[WIDTH]) begin
          rem_d = trialDiff;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trialRem;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        quot_d   = signQuot_q ? -dvd_q : dvd_q;
        remOut_d = signRem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        dbz_d    = 1'b0;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remOut_q;
  assign div_by_zero = dbz_q;

endmodule
